instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream stage of the KGP-RISC single-cycle datapath. Owns the program counter and fetches one 32-bit instruction at a time over a request/response instruction-memory port. Presents the instruction to decode/datapath with a valid/ready handshake. Resolves the next PC from the datapath's branch request and ALU flags, and supplies the link address for bl.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; must be word aligned
ADDR_W, 32, PC / address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
imem_req  out  1  one-cycle fetch request pulse
imem_addr  out  ADDR_W  fetch address, valid while imem_req=1
imem_rvalid  in  1  response strobe; earliest one cycle after imem_req
imem_rdata  in  32  instruction word, valid with imem_rvalid
instr_valid  out  1  instr/instr_pc/link_addr valid
instr_ready  in  1  datapath consumes the instruction this cycle
instr  out  32  fetched instruction
instr_pc  out  ADDR_W  address of instr
link_addr  out  ADDR_W  instr_pc+4, used by bl write-back to r31
br_valid  in  1  consumed instruction is a branch; sampled only on accept
br_cond  in  3  branch condition code (package enum)
br_target  in  ADDR_W  branch target (label or register value for br)
flag_carry, flag_zero, flag_neg  in  1 each  ALU flags of the consumed instruction
halt  in  1  suppress new fetches
instr_count  out  32  number of accepted instructions
misalign_err  out  1  sticky: a taken target had target[1:0]!=0

Behaviour:
- accept = instr_valid & instr_ready.
- Reset: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr/instr_pc/link_addr=0, instr_count=0, misalign_err=0. instr_ready and br_* are ignored during rst. imem shares rst and drops any pending response.
- FSM states: IDLE, FETCH, WAIT, HOLD.
  - IDLE: one cycle after reset, then go to FETCH.
  - FETCH: if !halt, assert imem_req with imem_addr=pc for exactly one cycle, then go to WAIT. If halt, stay with no request.
  - WAIT: on imem_rvalid, register instr=imem_rdata, instr_pc=pc, link_addr=pc+4, instr_valid=1, then go to HOLD. The pc value used is the one sent in the request.
  - HOLD: hold all outputs stable until accept. On accept: instr_valid=0, instr_count+=1, pc=next_pc, go to FETCH.
- imem_rvalid outside WAIT is ignored.
- Minimum loop: 3 cycles per instruction with zero-wait memory (FETCH, WAIT, HOLD+accept).
- next_pc, computed combinationally at accept:
  - taken = br_valid & cond_true(br_cond, flags).
  - next_pc = taken ? {br_target[ADDR_W-1:2], 2'b00} : pc+4.
  - If taken and br_target[1:0]!=0, set misalign_err (sticky until rst).
- br_cond values: ALWAYS(0: b, bl, br), Z(1: bz), NZ(2: bnz), CY(3: bcy), NCY(4: bncy), LTZ(5: bltz, uses flag_neg); 6 and 7 reserved, treated as not taken.
- pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0). instr_count also wraps.
- halt does not cancel an outstanding request or a HOLD instruction; it only blocks entry from FETCH to WAIT.
- br_* and flag inputs are don't-care when accept=0.
- rst in any state returns to the reset state next cycle; an in-flight response is discarded.

Decomposition:
- Package kgp_risc_pkg: br_cond_e enum (values above), fetch_state_e enum, INSTR_W=32, PC_STEP=4.
- One sub-module: branch_resolve (combinational), taking br_valid, br_cond, flags, br_target and pc, and producing next_pc, taken and misalign. FSM, PC, counter and output registers stay in the top module.

Test Plan:
- Reset then zero-wait memory, ready=1, no branches -> imem_addr sequence 0,4,8,12; one instruction accepted every 3 cycles; instr_count=4 after 4 accepts.
- bz with br_target=0x40: flag_zero=1 -> next imem_addr=0x40, link_addr=instr_pc+4. Repeat with flag_zero=0 -> next imem_addr=instr_pc+4.
- Response delayed 5 cycles, with ready low for 3 cycles in HOLD -> instr and instr_pc stable throughout; no second imem_req before accept.
- br_cond=ALWAYS, br_target=0x102 -> next fetch at 0x100, misalign_err=1 and still 1 after 10 further instructions.
- halt=1 in FETCH for 4 cycles -> no imem_req. After halt drops, the request goes out with the unchanged pc.
- rst asserted in WAIT with a late rvalid of 0xDEADBEEF -> instr_valid stays 0, next fetch is at RESET_PC, instr_count=0.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared types and constants for the KGP-RISC fetch stage.
package kgp_risc_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  // Branch condition codes carried with a consumed branch instruction.
  typedef enum logic [2:0] {
    BR_ALWAYS = 3'd0,  // b, bl, br
    BR_Z      = 3'd1,  // bz
    BR_NZ     = 3'd2,  // bnz
    BR_CY     = 3'd3,  // bcy
    BR_NCY    = 3'd4,  // bncy
    BR_LTZ    = 3'd5,  // bltz
    BR_RSV6   = 3'd6,  // reserved, never taken
    BR_RSV7   = 3'd7   // reserved, never taken
  } br_cond_e;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  // Evaluates a branch condition against the ALU flags of the branch instruction.
  function automatic logic condTrue(input br_cond_e cond, input logic carry,
                                    input logic zero, input logic neg);
    logic res;
    res = 1'b0;
    case (cond)
      BR_ALWAYS: res = 1'b1;
      BR_Z:      res = zero;
      BR_NZ:     res = ~zero;
      BR_CY:     res = carry;
      BR_NCY:    res = ~carry;
      BR_LTZ:    res = neg;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_branch_resolve.sv
// Combinational next-PC selection for the instruction just consumed.
module branch_resolve
  import kgp_risc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic              flag_carry,
  input  logic              flag_zero,
  input  logic              flag_neg,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] nextPc,
  output logic              taken,
  output logic              misalign
);

  // Taken branches go to the word-aligned target, everything else falls through.
  always_comb begin
    taken    = br_valid & condTrue(br_cond_e'(br_cond), flag_carry, flag_zero, flag_neg);
    nextPc   = taken ? {br_target[ADDR_W-1:2], 2'b00} : pc + ADDR_W'(PC_STEP);
    misalign = taken & (br_target[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per request and
// presents it downstream until the datapath takes it.
//
// Downstream handshake: instr_valid rises once the response is captured and
// stays high with instr/instr_pc/link_addr frozen until a cycle where
// instr_ready is also high; that cycle is the accept, where the branch inputs
// and flags are sampled and the next PC is chosen.
module instr_fetch_unit
  import kgp_risc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  link_addr,
  input  logic               br_valid,
  input  logic [2:0]         br_cond,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               flag_carry,
  input  logic               flag_zero,
  input  logic               flag_neg,
  input  logic               halt,
  output logic [31:0]        instr_count,
  output logic               misalign_err,
  output fetch_state_e       dbgState
);

  fetch_state_e      state;
  fetch_state_e      nextState;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] nextPc;
  logic              taken;
  logic              misalign;
  logic              accept;

  assign accept = instr_valid & instr_ready;

  branch_resolve #(.ADDR_W(ADDR_W)) uBranch (
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .br_target  (br_target),
    .pc         (pc),
    .nextPc     (nextPc),
    .taken      (taken),
    .misalign   (misalign)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  // Sequencing: one request per instruction, halt only gates leaving FETCH.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  nextState = ST_FETCH;
      ST_FETCH: if (!halt) nextState = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) nextState = ST_HOLD;
      ST_HOLD:  if (accept) nextState = ST_FETCH;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Request port and state visibility.
  always_comb begin
    imem_req  = (state == ST_FETCH) && !halt;
    imem_addr = pc;
    dbgState  = state;
  end

  // PC, captured instruction, counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr_valid  <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
      link_addr    <= '0;
      instr_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      // pc is untouched between request and response, so it is the request address.
      if (state == ST_WAIT && imem_rvalid) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        link_addr   <= pc + ADDR_W'(PC_STEP);
        instr_valid <= 1'b1;
      end
      if (accept) begin
        instr_valid <= 1'b0;
        instr_count <= instr_count + 32'd1;
        pc          <= nextPc;
        if (misalign) misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a latency-programmable memory responder plus a
// PC/count/error reference model updated at every accept.
module tb_instr_fetch_unit;
  import kgp_risc_pkg::*;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

  logic         clk;
  logic         rst;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic [31:0]  link_addr;
  logic         br_valid;
  logic [2:0]   br_cond;
  logic [31:0]  br_target;
  logic         flag_carry;
  logic         flag_zero;
  logic         flag_neg;
  logic         halt;
  logic [31:0]  instr_count;
  logic         misalign_err;
  fetch_state_e dbgState;

  int nRun = 0;
  int nFail = 0;
  int cyc = 0;
  int lastAcc = 0;

  // reference model
  logic [31:0] mPc;
  int          mCount;
  logic        mMis;

  // memory responder controls / state
  logic [31:0] memKey;
  int          memLat = 1;
  logic        respEnable = 1'b0;
  logic        respValid = 1'b0;
  logic [31:0] respData = '0;
  logic        injValid = 1'b0;
  logic [31:0] injData = '0;
  logic [31:0] reqQ[$];
  int          reqRd = 0;

  assign imem_rvalid = respValid | injValid;
  assign imem_rdata  = injValid ? injData : respData;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC_TB)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .link_addr    (link_addr),
    .br_valid     (br_valid),
    .br_cond      (br_cond),
    .br_target    (br_target),
    .flag_carry   (flag_carry),
    .flag_zero    (flag_zero),
    .flag_neg     (flag_neg),
    .halt         (halt),
    .instr_count  (instr_count),
    .misalign_err (misalign_err),
    .dbgState     (dbgState)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory image: a fixed pseudo-random word per address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ memKey;
  endfunction

  // Spec-level branch condition table.
  function automatic logic refTaken(input logic bv, input logic [2:0] bc,
                                    input logic c, input logic z, input logic n);
    if (!bv) return 1'b0;
    case (bc)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return c;
      3'd4:    return !c;
      3'd5:    return n;
      default: return 1'b0;
    endcase
  endfunction

  // Memory responder and request monitor (acts at falling edges).
  initial begin
    int          pend;
    logic [31:0] pendAddr;
    pend = 0;
    pendAddr = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) reqQ.push_back(imem_addr);
      if (!respEnable) begin
        respValid = 1'b0;
        pend = 0;
      end else begin
        respValid = 1'b0;
        if (pend > 0) begin
          pend = pend - 1;
          if (pend == 0) begin
            respValid = 1'b1;
            respData  = memWord(pendAddr);
          end
        end
        if (imem_req === 1'b1) begin
          pend = memLat;
          pendAddr = imem_addr;
        end
      end
    end
  end

  // Drives one instruction through HOLD and accept, checking it against the model.
  task automatic doInstr(input logic bv, input logic [2:0] bc, input logic [31:0] bt,
                         input logic fc, input logic fz, input logic fn,
                         input int readyDelay, input logic haltNext, input int expGap);
    int          guard;
    logic [31:0] expInstr;
    logic [31:0] head;
    int          nReq;
    logic        tk;
    guard = 0;
    while (instr_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    nRun++;
    if (instr_valid !== 1'b1) begin
      nFail++;
      $display("FAIL valid_timeout: instr_valid=%b required 1 (pc %h)", instr_valid, mPc);
      return;
    end
    expInstr = memWord(mPc);
    nReq = reqQ.size() - reqRd;
    head = (nReq > 0) ? reqQ[reqRd] : 32'hXXXX_XXXX;
    reqRd = reqQ.size();
    nRun++;
    if (nReq != 1 || head !== mPc) begin
      nFail++;
      $display("FAIL fetch_addr: %0d requests, first %h; required 1 request at %h", nReq, head, mPc);
    end
    nRun++;
    if (instr !== expInstr) begin
      nFail++;
      $display("FAIL instr: got %h required %h", instr, expInstr);
    end
    nRun++;
    if (instr_pc !== mPc) begin
      nFail++;
      $display("FAIL instr_pc: got %h required %h", instr_pc, mPc);
    end
    nRun++;
    if (link_addr !== mPc + 32'd4) begin
      nFail++;
      $display("FAIL link_addr: got %h required %h", link_addr, mPc + 32'd4);
    end
    for (int i = 0; i < readyDelay; i++) begin
      @(negedge clk);
      nRun++;
      if (instr_valid !== 1'b1 || instr !== expInstr || instr_pc !== mPc || imem_req !== 1'b0) begin
        nFail++;
        $display("FAIL hold_stable: valid=%b instr=%h pc=%h req=%b required 1/%h/%h/0",
                 instr_valid, instr, instr_pc, imem_req, expInstr, mPc);
      end
    end
    instr_ready = 1'b1;
    br_valid    = bv;
    br_cond     = bc;
    br_target   = bt;
    flag_carry  = fc;
    flag_zero   = fz;
    flag_neg    = fn;
    halt        = haltNext;
    @(negedge clk);
    instr_ready = 1'b0;
    br_valid    = 1'($urandom);
    br_cond     = 3'($urandom);
    br_target   = $urandom;
    flag_carry  = 1'($urandom);
    flag_zero   = 1'($urandom);
    flag_neg    = 1'($urandom);
    tk = refTaken(bv, bc, fc, fz, fn);
    mCount++;
    if (tk) begin
      mPc = bt & ~32'h3;
      if (bt[1:0] != 2'b00) mMis = 1'b1;
    end else begin
      mPc = mPc + 32'd4;
    end
    nRun++;
    if (instr_valid !== 1'b0) begin
      nFail++;
      $display("FAIL valid_clear: instr_valid=%b required 0", instr_valid);
    end
    nRun++;
    if (instr_count !== 32'(mCount)) begin
      nFail++;
      $display("FAIL instr_count: got %0d required %0d", instr_count, mCount);
    end
    nRun++;
    if (misalign_err !== mMis) begin
      nFail++;
      $display("FAIL misalign_err: got %b required %b", misalign_err, mMis);
    end
    if (expGap > 0) begin
      nRun++;
      if (cyc - lastAcc != expGap) begin
        nFail++;
        $display("FAIL accept_gap: got %0d cycles required %0d", cyc - lastAcc, expGap);
      end
    end
    lastAcc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nRun++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
        link_addr !== 32'h0 || instr_count !== 32'h0 || misalign_err !== 1'b0) begin
      nFail++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h link=%h cnt=%0d mis=%b required all 0",
               imem_req, instr_valid, instr, instr_pc, link_addr, instr_count, misalign_err);
    end
    mPc = RESET_PC_TB;
    mCount = 0;
    mMis = 1'b0;
    memLat = 1;
    respEnable = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_bz();
    doInstr(1'b1, 3'd1, 32'h40, 1'($urandom), 1'b1, 1'($urandom), 0, 1'b0, 3);
    doInstr(1'b1, 3'd1, 32'h40, 1'($urandom), 1'b0, 1'($urandom), 0, 1'b0, 3);
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_delayed_hold();
    memLat = 5;
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0);
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 10);
    memLat = 1;
  endtask

  task automatic test_halt();
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nRun++;
      if (imem_req !== 1'b0) begin
        nFail++;
        $display("FAIL halt_req: imem_req=%b required 0", imem_req);
      end
    end
    @(posedge clk);
    #1 halt = 1'b0;
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int i = 0; i < 30; i++) begin
      memLat = $urandom_range(1, 4);
      tgt = $urandom & ~32'h3;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      doInstr(1'($urandom), 3'($urandom), tgt, 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), 1'b0, 0);
    end
    memLat = 1;
  endtask

  task automatic test_reset_in_wait();
    memLat = 5;
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    respEnable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nRun++;
    if (dbgState !== ST_WAIT || instr_valid !== 1'b0) begin
      nFail++;
      $display("FAIL wait_state: state=%0d valid=%b required %0d/0", dbgState, instr_valid, ST_WAIT);
    end
    rst = 1'b1;
    @(negedge clk);
    nRun++;
    if (instr_valid !== 1'b0 || instr_count !== 32'h0 || imem_req !== 1'b0 || misalign_err !== 1'b0) begin
      nFail++;
      $display("FAIL rst_in_wait: valid=%b cnt=%0d req=%b mis=%b required 0/0/0/0",
               instr_valid, instr_count, imem_req, misalign_err);
    end
    rst = 1'b0;
    injData = 32'hDEAD_BEEF;
    injValid = 1'b1;
    @(posedge clk);
    #1;
    injValid = 1'b0;
    reqRd = reqQ.size();
    mPc = RESET_PC_TB;
    mCount = 0;
    mMis = 1'b0;
    memLat = 1;
    respEnable = 1'b1;
    @(negedge clk);
    nRun++;
    if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF) begin
      nFail++;
      $display("FAIL late_rvalid: valid=%b instr=%h required 0 and not deadbeef", instr_valid, instr);
    end
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_misalign();
    doInstr(1'b1, 3'd0, 32'h102, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 11; i++)
      doInstr(1'b1, 3'($urandom_range(6, 7)), 32'h0000_0203, 1'($urandom), 1'($urandom),
              1'($urandom), 0, 1'b0, 0);
  endtask

  task automatic test_wrap();
    doInstr(1'b1, 3'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    doInstr(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    memKey      = $urandom;
    rst         = 1'b1;
    instr_ready = 1'b0;
    br_valid    = 1'b0;
    br_cond     = 3'd0;
    br_target   = '0;
    flag_carry  = 1'b0;
    flag_zero   = 1'b0;
    flag_neg    = 1'b0;
    halt        = 1'b0;
    mPc         = RESET_PC_TB;
    mCount      = 0;
    mMis        = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_bz();
    test_delayed_hold();
    test_halt();
    test_random();
    test_reset_in_wait();
    test_misalign();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
